// File: rtl/contador_scan_ctrl.sv
// contador_scan_ctrl: walks the per-FIFO push counters of the transaction
// layer one index at a time. For each index it issues a one-cycle request,
// waits for the counter block to answer, streams the returned count out, and
// adds it to a running total. If an answer does not arrive in time, the scan
// is cut short and a sticky error flag is raised. Every output is registered.
module contador_scan_ctrl #(
  parameter int NUM_CNT = 5,
  parameter int TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic       start,
  input  logic       idle,
  input  logic [4:0] ctr_data,
  input  logic       ctr_valid,
  output logic       ctr_req,
  output logic [2:0] ctr_idx,
  output logic [4:0] data_out,
  output logic [2:0] idx_out,
  output logic       data_valid,
  output logic [7:0] total,
  output logic       done,
  output logic       error,
  output logic       busy
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t            state, state_nxt;
  logic [2:0]        index, index_nxt;
  logic [TO_W-1:0]   to_cnt;
  logic              scan_start;
  logic              capture;
  logic              timeout_hit;

  // Next-state decode plus the single-cycle events that drive the datapath
  always_comb begin
    state_nxt   = state;
    index_nxt   = index;
    scan_start  = 1'b0;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (start && idle) begin
          scan_start = 1'b1;
          index_nxt  = 3'd0;
          state_nxt  = REQ;
        end
      end
      REQ: begin
        state_nxt = WAIT;
      end
      WAIT: begin
        if (ctr_valid) begin
          capture = 1'b1;
          if (index == 3'(NUM_CNT - 1)) begin
            state_nxt = DONE;
          end else begin
            index_nxt = 3'(index + 3'd1);
            state_nxt = REQ;
          end
        end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
          // This silent cycle is the TIMEOUT-th one: abandon remaining indices
          timeout_hit = 1'b1;
          state_nxt   = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Scan index and timeout counter; the timeout count restarts on every request
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      index  <= 3'd0;
      to_cnt <= '0;
    end else begin
      index <= index_nxt;
      if (state == REQ) begin
        to_cnt <= '0;
      end else if (state == WAIT && !ctr_valid) begin
        to_cnt <= to_cnt + TO_W'(1);
      end
    end
  end

  // Registered outputs, decoded from the next state so they line up with it
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      ctr_req    <= 1'b0;
      ctr_idx    <= 3'd0;
      data_out   <= 5'd0;
      idx_out    <= 3'd0;
      data_valid <= 1'b0;
      total      <= 8'd0;
      done       <= 1'b0;
      error      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      ctr_req    <= (state_nxt == REQ);
      done       <= (state_nxt == DONE);
      busy       <= (state_nxt != IDLE);
      data_valid <= capture;
      // ctr_idx only moves when a new request goes out, otherwise it holds
      if (state_nxt == REQ) begin
        ctr_idx <= index_nxt;
      end
      if (capture) begin
        data_out <= ctr_data;
        idx_out  <= index;
      end
      if (scan_start) begin
        total <= 8'd0;
      end else if (capture) begin
        total <= total + {3'b000, ctr_data};
      end
      if (scan_start) begin
        error <= 1'b0;
      end else if (timeout_hit) begin
        error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_contador_scan_ctrl.sv
// Bench for contador_scan_ctrl: table of whole-scan vectors (counts, a
// counter index that never answers, expected total/error/done cycle) plus
// hand-written sequences for reset, idle gating, mid-scan reset and
// back-to-back scans. Cycle c is the c-th clock after start is driven.
module tb_contador_scan_ctrl;

  localparam int NUM_CNT = 5;
  localparam int TIMEOUT = 4;

  logic       clk;
  logic       reset_L;
  logic       start;
  logic       idle;
  logic [4:0] ctr_data;
  logic       ctr_valid;
  logic       ctr_req;
  logic [2:0] ctr_idx;
  logic [4:0] data_out;
  logic [2:0] idx_out;
  logic       data_valid;
  logic [7:0] total;
  logic       done;
  logic       error;
  logic       busy;

  contador_scan_ctrl #(.NUM_CNT(NUM_CNT), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .start      (start),
    .idle       (idle),
    .ctr_data   (ctr_data),
    .ctr_valid  (ctr_valid),
    .ctr_req    (ctr_req),
    .ctr_idx    (ctr_idx),
    .data_out   (data_out),
    .idx_out    (idx_out),
    .data_valid (data_valid),
    .total      (total),
    .done       (done),
    .error      (error),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [39:0] cnt;
    int          blk;
    int          total;
    int          err;
    int          done_cyc;
  } vec_t;

  vec_t       tbl [6];
  logic [4:0] mcnt [8];
  int         mblk;
  logic       spur;
  logic       pend;
  logic [2:0] pidx;
  int         n_vec;
  int         n_fail;

  // Counter block model: answers one cycle after each request unless the
  // requested index is the one marked as dead; spur forces valid high always
  initial begin
    pend      = 1'b0;
    pidx      = 3'd0;
    ctr_valid = 1'b0;
    ctr_data  = 5'd0;
    forever begin
      @(negedge clk);
      if (!reset_L) begin
        pend      = 1'b0;
        ctr_valid = 1'b0;
        ctr_data  = 5'd0;
      end else begin
        ctr_valid = spur || (pend && (int'(pidx) != mblk));
        ctr_data  = pend ? mcnt[pidx] : 5'd31;
        pend      = ctr_req;
        pidx      = ctr_idx;
      end
    end
  end

  function automatic logic [39:0] pack5(input int a, input int b, input int c,
                                        input int d, input int e);
    logic [39:0] v;
    v         = '0;
    v[4:0]    = 5'(a);
    v[9:5]    = 5'(b);
    v[14:10]  = 5'(c);
    v[19:15]  = 5'(d);
    v[24:20]  = 5'(e);
    return v;
  endfunction

  task automatic chk(input string nm, input int c, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cyc %0d: got %0d expected %0d", nm, c, act, exp);
    end
  endtask

  task automatic load_counts(input int k);
    for (int i = 0; i < 8; i++) mcnt[i] = tbl[k].cnt[i*5 +: 5];
    mblk = tbl[k].blk;
  endtask

  task automatic run_scan(input int k);
    int last_req;
    int n_dv;
    int i;
    load_counts(k);
    n_dv     = (mblk >= 0 && mblk < NUM_CNT) ? mblk : NUM_CNT;
    last_req = (mblk >= 0 && mblk < NUM_CNT) ? mblk : NUM_CNT - 1;
    @(negedge clk);
    start = 1'b1;
    idle  = 1'b1;
    for (int c = 1; c <= tbl[k].done_cyc + 1; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      chk($sformatf("v%0d ctr_req", k), c, int'(ctr_req),
          int'((c % 2 == 1) && ((c - 1) / 2 <= last_req)));
      if (c <= 2 * last_req + 2)
        chk($sformatf("v%0d ctr_idx", k), c, int'(ctr_idx), (c - 1) / 2);
      chk($sformatf("v%0d data_valid", k), c, int'(data_valid),
          int'((c % 2 == 1) && (c >= 3) && ((c - 3) / 2 < n_dv)));
      if (c >= 3 && n_dv > 0) begin
        i = (c - 3) / 2;
        if (i >= n_dv) i = n_dv - 1;
        chk($sformatf("v%0d data_out", k), c, int'(data_out), int'(mcnt[i]));
        chk($sformatf("v%0d idx_out", k), c, int'(idx_out), i);
      end
      chk($sformatf("v%0d done", k), c, int'(done), int'(c == tbl[k].done_cyc));
      chk($sformatf("v%0d busy", k), c, int'(busy), int'(c <= tbl[k].done_cyc));
      if (c == 1) begin
        chk($sformatf("v%0d error_clr", k), c, int'(error), 0);
        chk($sformatf("v%0d total_clr", k), c, int'(total), 0);
      end
      if (c >= tbl[k].done_cyc) begin
        chk($sformatf("v%0d total", k), c, int'(total), tbl[k].total);
        chk($sformatf("v%0d error", k), c, int'(error), tbl[k].err);
      end
    end
  endtask

  initial begin
    n_vec   = 0;
    n_fail  = 0;
    spur    = 1'b0;
    mblk    = -1;
    for (int i = 0; i < 8; i++) mcnt[i] = 5'd0;

    tbl[0] = '{cnt: pack5(3, 0, 15, 7, 1),    blk: -1, total: 26, err: 0, done_cyc: 11};
    tbl[1] = '{cnt: pack5(5, 9, 4, 2, 8),     blk: 2,  total: 14, err: 1, done_cyc: 10};
    tbl[2] = '{cnt: pack5(15, 15, 15, 15, 15), blk: -1, total: 75, err: 0, done_cyc: 11};
    tbl[3] = '{cnt: pack5(6, 6, 6, 6, 6),     blk: 0,  total: 0,  err: 1, done_cyc: 6};
    tbl[4] = '{cnt: pack5(1, 2, 3, 4, 5),     blk: 4,  total: 10, err: 1, done_cyc: 14};
    tbl[5] = '{cnt: pack5(0, 1, 0, 1, 15),    blk: -1, total: 17, err: 0, done_cyc: 11};

    // Reset: everything zero, then idle with junk valid and no start
    reset_L = 1'b0;
    start   = 1'b0;
    idle    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst ctr_req", 0, int'(ctr_req), 0);
    chk("rst ctr_idx", 0, int'(ctr_idx), 0);
    chk("rst data_valid", 0, int'(data_valid), 0);
    chk("rst data_out", 0, int'(data_out), 0);
    chk("rst idx_out", 0, int'(idx_out), 0);
    chk("rst total", 0, int'(total), 0);
    chk("rst done", 0, int'(done), 0);
    chk("rst error", 0, int'(error), 0);
    chk("rst busy", 0, int'(busy), 0);
    reset_L = 1'b1;
    idle    = 1'b1;
    spur    = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("idle ctr_req", c, int'(ctr_req), 0);
      chk("idle data_valid", c, int'(data_valid), 0);
      chk("idle busy", c, int'(busy), 0);
      chk("idle total", c, int'(total), 0);
    end
    spur = 1'b0;

    // Table-driven full scans
    for (int k = 0; k < 6; k++) run_scan(k);

    // Reset in cycle 6 of a scan: abandoned, no done afterwards
    load_counts(0);
    @(negedge clk);
    start = 1'b1;
    idle  = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 6) reset_L = 1'b0;
      if (c == 7) begin
        chk("mrst busy", c, int'(busy), 0);
        chk("mrst ctr_req", c, int'(ctr_req), 0);
        chk("mrst data_valid", c, int'(data_valid), 0);
        chk("mrst total", c, int'(total), 0);
        chk("mrst data_out", c, int'(data_out), 0);
        chk("mrst ctr_idx", c, int'(ctr_idx), 0);
        reset_L = 1'b1;
      end
      if (c > 7) begin
        chk("mrst done", c, int'(done), 0);
        chk("mrst no_req", c, int'(ctr_req), 0);
      end
    end
    run_scan(1);
    run_scan(0);

    // Idle gating: start high while idle low for 5 cycles
    load_counts(0);
    @(negedge clk);
    start = 1'b1;
    idle  = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      if (c <= 5) begin
        chk("gate ctr_req", c, int'(ctr_req), 0);
        chk("gate busy", c, int'(busy), 0);
      end
      if (c == 5) idle = 1'b1;
      if (c == 6) begin
        chk("gate first_req", c, int'(ctr_req), 1);
        chk("gate first_idx", c, int'(ctr_idx), 0);
        start = 1'b0;
      end
      if (c == 8) begin
        chk("gate dv", c, int'(data_valid), 1);
        chk("gate data", c, int'(data_out), 3);
        chk("gate req2_idx", c, int'(ctr_idx), 1);
      end
      if (c == 16) begin
        chk("gate done", c, int'(done), 1);
        chk("gate total", c, int'(total), 26);
      end
      if (c == 17) chk("gate busy_end", c, int'(busy), 0);
    end

    // Back-to-back: start held, second scan requests at 13 and restarts total
    load_counts(0);
    @(negedge clk);
    start = 1'b1;
    idle  = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (c == 11) begin
        chk("b2b done1", c, int'(done), 1);
        chk("b2b total1", c, int'(total), 26);
      end
      if (c == 12) begin
        chk("b2b gap_req", c, int'(ctr_req), 0);
        chk("b2b gap_busy", c, int'(busy), 0);
        chk("b2b gap_total", c, int'(total), 26);
      end
      if (c == 13) begin
        chk("b2b req2", c, int'(ctr_req), 1);
        chk("b2b idx2", c, int'(ctr_idx), 0);
        chk("b2b total_clr", c, int'(total), 0);
        start = 1'b0;
      end
      if (c == 22) chk("b2b early_done", c, int'(done), 0);
      if (c == 23) begin
        chk("b2b done2", c, int'(done), 1);
        chk("b2b total2", c, int'(total), 26);
        chk("b2b error2", c, int'(error), 0);
      end
      if (c == 24) chk("b2b idle_end", c, int'(busy), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
